tempsens_uart_host: RTL

Host-side counterpart of the on-chip temperature-sensor UART link. It sends one command byte on the serial line to the sensor's rx pin, then collects the 3-byte averaged-count response from the sensor's tx pin and assembles it into a 24-bit result. It is used in the FPGA bring-up harness and the system testbench as the sensor's readout master. It contains its own 8N1 transmitter and receiver, a sequencing FSM and a response timeout.

---
 rtl/tempsens_uart_host.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tempsens_uart_host.sv
`default_nettype none
// ============================================================================
// Module   : tempsens_uart_host
// Purpose  : Host-side readout master for the temperature-sensor UART link.
//            Sends one 8N1 command byte on o_tx, then collects a 3-byte
//            averaged-count reply on i_rx (byte0 first) and presents it as a
//            24-bit result. Each reply start bit must arrive within
//            TIMEOUT_CLKS cycles of the host being ready for it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk            system clock
//            reset          synchronous, active-high reset
//            i_start        request one readout (sampled only when idle)
//            i_rx           serial in from the sensor tx (idle high)
//            o_tx           serial out to the sensor rx (idle high)
//            o_result       last successfully assembled average, byte0=[7:0]
//            o_result_valid 1-cycle pulse when o_result updates
//            o_busy         high from accepted start until back in idle
//            o_timeout_err  1-cycle pulse on response timeout
//            o_frame_err    1-cycle pulse on bad stop bit
// ============================================================================
module tempsens_uart_host #(
  parameter int         CLK_FREQ     = 10000,
  parameter int         BAUD         = 1000,
  parameter logic [7:0] CMD_BYTE     = 8'h01,
  parameter int         TIMEOUT_CLKS = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_rx,
  output logic        o_tx,
  output logic [23:0] o_result,
  output logic        o_result_valid,
  output logic        o_busy,
  output logic        o_timeout_err,
  output logic        o_frame_err
);

  localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);
  localparam int c_TMO_W        = $clog2(TIMEOUT_CLKS);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(c_CLKS_PER_BIT / 2 - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_TX_START = 4'd1,
    S_TX_DATA  = 4'd2,
    S_TX_STOP  = 4'd3,
    S_RX_WAIT  = 4'd4,
    S_RX_START = 4'd5,
    S_RX_DATA  = 4'd6,
    S_RX_STOP  = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rx_meta;
  logic                r_rx_s;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_TMO_W-1:0]  r_tmo;
  logic [2:0]          r_bit;
  logic [1:0]          r_idx;
  logic [7:0]          r_shift;
  logic [2:0][7:0]     r_slot;
  logic [23:0]         r_result;
  logic                r_result_valid;
  logic                r_timeout_err;
  logic                r_frame_err;

  logic w_cnt_last;
  logic w_cnt_clr;
  logic w_bit_clr;
  logic w_bit_adv;
  logic w_tmo_clr;
  logic w_tmo_inc;
  logic w_idx_clr;
  logic w_idx_inc;
  logic w_shift;
  logic w_store;
  logic w_commit;
  logic w_tmo_err;
  logic w_frm_err;

  assign w_cnt_last = (r_cnt == c_CNT_LAST);

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state and datapath strobes
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_bit_clr   = 1'b0;
    w_bit_adv   = 1'b0;
    w_tmo_clr   = 1'b0;
    w_tmo_inc   = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_shift     = 1'b0;
    w_store     = 1'b0;
    w_commit    = 1'b0;
    w_tmo_err   = 1'b0;
    w_frm_err   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (i_start) begin
          w_state_nxt = S_TX_START;
        end
      end

      S_TX_START: begin
        if (w_cnt_last) begin
          w_cnt_clr   = 1'b1;
          w_bit_clr   = 1'b1;
          w_state_nxt = S_TX_DATA;
        end
      end

      S_TX_DATA: begin
        if (w_cnt_last) begin
          w_cnt_clr = 1'b1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_TX_STOP;
          end else begin
            w_bit_adv = 1'b1;
          end
        end
      end

      S_TX_STOP: begin
        if (w_cnt_last) begin
          w_cnt_clr   = 1'b1;
          w_tmo_clr   = 1'b1;
          w_idx_clr   = 1'b1;
          w_state_nxt = S_RX_WAIT;
        end
      end

      S_RX_WAIT: begin
        // Bit timer is held at zero so RX_START measures from the falling edge.
        w_cnt_clr = 1'b1;
        if (!r_rx_s) begin
          w_bit_clr   = 1'b1;
          w_state_nxt = S_RX_START;
        end else if (r_tmo == c_TMO_LAST) begin
          w_tmo_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end

      S_RX_START: begin
        // A line already high again at mid start bit was a glitch; the
        // timeout keeps its count so glitches cannot extend the wait.
        if (r_cnt == c_CNT_MID) begin
          w_cnt_clr = 1'b1;
          if (r_rx_s) begin
            w_state_nxt = S_RX_WAIT;
          end else begin
            w_state_nxt = S_RX_DATA;
          end
        end
      end

      S_RX_DATA: begin
        if (w_cnt_last) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_RX_STOP;
          end else begin
            w_bit_adv = 1'b1;
          end
        end
      end

      S_RX_STOP: begin
        if (w_cnt_last) begin
          w_cnt_clr = 1'b1;
          if (!r_rx_s) begin
            w_frm_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_store = 1'b1;
            if (r_idx == 2'd2) begin
              w_state_nxt = S_DONE;
            end else begin
              w_idx_inc   = 1'b1;
              w_tmo_clr   = 1'b1;
              w_state_nxt = S_RX_WAIT;
            end
          end
        end
      end

      S_DONE: begin
        w_cnt_clr   = 1'b1;
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Datapath: synchronizer, counters, shift register, shadow and result
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta      <= 1'b1;
      r_rx_s         <= 1'b1;
      r_cnt          <= '0;
      r_tmo          <= '0;
      r_bit          <= '0;
      r_idx          <= '0;
      r_shift        <= '0;
      r_slot         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_tmo_clr) begin
        r_tmo <= '0;
      end else if (w_tmo_inc) begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (w_bit_clr) begin
        r_bit <= '0;
      end else if (w_bit_adv) begin
        r_bit <= r_bit + 1'b1;
      end

      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end

      if (w_shift) begin
        r_shift <= {r_rx_s, r_shift[7:1]};
      end

      if (w_store) begin
        case (r_idx)
          2'd0:    r_slot[0] <= r_shift;
          2'd1:    r_slot[1] <= r_shift;
          default: r_slot[2] <= r_shift;
        endcase
      end

      if (w_commit) begin
        r_result <= r_slot;
      end

      // Pulses land in the first idle cycle, together with busy falling.
      r_result_valid <= w_commit;
      r_timeout_err  <= w_tmo_err;
      r_frame_err    <= w_frm_err;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      S_TX_START: o_tx = 1'b0;
      S_TX_DATA:  o_tx = CMD_BYTE[r_bit];
      default:    o_tx = 1'b1;
    endcase
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_timeout_err  = r_timeout_err;
  assign o_frame_err    = r_frame_err;

endmodule
`default_nettype wire
